// File: rtl/laser310_bank_ctrl.sv
// Laser 310 SRAM bank controller: decodes Z80 memory/IO cycles into registered
// SRAM strobes and high address bits, and stretches activity LEDs.
module laser310_bank_ctrl #(
  parameter logic [3:0]  BANK_PORT = 4'h7,
  parameter logic [15:0] LED_HOLD  = 16'd50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] Addr,
  input  logic [3:0] AddrIO,
  input  logic       WR_N,
  input  logic       RD_N,
  input  logic       MREQ_N,
  input  logic       IORQ_N,
  input  logic [1:0] D1D0,
  output logic [1:0] RAM_A1514,
  output logic       RAM_CS_N,
  output logic       RAM_OE_N,
  output logic       RAM_WE_N,
  output logic       led1,
  output logic       led2,
  output logic [1:0] bank
);

  localparam int unsigned NSTB = 4;
  localparam int unsigned S_WR = 3;
  localparam int unsigned S_RD = 2;
  localparam int unsigned S_MREQ = 1;
  localparam int unsigned S_IORQ = 0;

  typedef enum logic [1:0] {IDLE, MEM_ACT, IO_WR, RECOVER} state_t;

  state_t            state;
  logic [NSTB-1:0]   sync1, sync2;
  logic              wr_s, rd_s, mreq_s, iorq_s;
  logic              is_read;
  logic              mem_req, io_req, in_win, go_mem, go_io, mem_end;
  logic [1:0]        win_a;
  logic [15:0]       cnt1, cnt2;

  function automatic logic [1:0] map_bank(input logic [1:0] b);
    return (b[1] == 1'b0) ? 2'b01 : b;
  endfunction

  // Two-flop synchronizers for the asynchronous bus strobes
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= {WR_N, RD_N, MREQ_N, IORQ_N};
      sync2 <= sync1;
    end
  end

  assign wr_s   = sync2[S_WR];
  assign rd_s   = sync2[S_RD];
  assign mreq_s = sync2[S_MREQ];
  assign iorq_s = sync2[S_IORQ];

  // Cycle qualification and window decode; Addr/AddrIO/D1D0 are only consumed
  // on the edge that leaves IDLE, so they need no synchronizer.
  always_comb begin
    mem_req = 1'b0;
    io_req  = 1'b0;
    in_win  = 1'b0;
    win_a   = 2'b00;
    mem_req = !mreq_s && iorq_s && (rd_s ^ wr_s);
    io_req  = !iorq_s && mreq_s && !wr_s && rd_s && (AddrIO == BANK_PORT);
    if (Addr == 5'b10111) begin
      in_win = 1'b1;
      win_a  = 2'b00;
    end else if (Addr[4:3] == 2'b11) begin
      in_win = 1'b1;
      win_a  = map_bank(bank);
    end
    go_mem  = (state == IDLE) && mem_req && in_win;
    go_io   = (state == IDLE) && !go_mem && io_req;
    mem_end = mreq_s || (is_read ? rd_s : wr_s) || (!rd_s && !wr_s);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      RAM_CS_N  <= 1'b1;
      RAM_OE_N  <= 1'b1;
      RAM_WE_N  <= 1'b1;
      RAM_A1514 <= 2'b00;
      bank      <= 2'b01;
      is_read   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (go_mem) begin
            state     <= MEM_ACT;
            RAM_A1514 <= win_a;
            RAM_CS_N  <= 1'b0;
            RAM_OE_N  <= rd_s;
            RAM_WE_N  <= wr_s;
            is_read   <= !rd_s;
          end else if (go_io) begin
            state <= IO_WR;
            bank  <= D1D0;
          end
        end
        MEM_ACT: begin
          if (mem_end) begin
            state    <= RECOVER;
            RAM_CS_N <= 1'b1;
            RAM_OE_N <= 1'b1;
            RAM_WE_N <= 1'b1;
          end
        end
        IO_WR: begin
          if (iorq_s || wr_s) state <= IDLE;
        end
        RECOVER: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // LED stretchers; led mirrors (count != 0) of the value being loaded
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt1 <= '0;
      led1 <= 1'b0;
    end else if (go_mem) begin
      cnt1 <= LED_HOLD;
      led1 <= (LED_HOLD != 16'd0);
    end else if (cnt1 != 16'd0) begin
      cnt1 <= cnt1 - 16'd1;
      led1 <= (cnt1 != 16'd1);
    end else begin
      led1 <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt2 <= '0;
      led2 <= 1'b0;
    end else if (go_io) begin
      cnt2 <= LED_HOLD;
      led2 <= (LED_HOLD != 16'd0);
    end else if (cnt2 != 16'd0) begin
      cnt2 <= cnt2 - 16'd1;
      led2 <= (cnt2 != 16'd1);
    end else begin
      led2 <= 1'b0;
    end
  end

endmodule

// File: tb/tb_laser310_bank_ctrl.sv
// Directed self-checking bench for laser310_bank_ctrl.
module tb_laser310_bank_ctrl;

  localparam logic [15:0] HOLD = 16'd40;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] Addr;
  logic [3:0] AddrIO;
  logic       WR_N, RD_N, MREQ_N, IORQ_N;
  logic [1:0] D1D0;
  logic [1:0] RAM_A1514;
  logic       RAM_CS_N, RAM_OE_N, RAM_WE_N;
  logic       led1, led2;
  logic [1:0] bank;

  int checks = 0;
  int errors = 0;

  laser310_bank_ctrl #(.BANK_PORT(4'h7), .LED_HOLD(HOLD)) dut (
    .clk(clk), .rst(rst), .Addr(Addr), .AddrIO(AddrIO),
    .WR_N(WR_N), .RD_N(RD_N), .MREQ_N(MREQ_N), .IORQ_N(IORQ_N),
    .D1D0(D1D0), .RAM_A1514(RAM_A1514), .RAM_CS_N(RAM_CS_N),
    .RAM_OE_N(RAM_OE_N), .RAM_WE_N(RAM_WE_N), .led1(led1), .led2(led2),
    .bank(bank)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_idle();
    WR_N = 1'b1; RD_N = 1'b1; MREQ_N = 1'b1; IORQ_N = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus_idle();
    tick(1);
    rst = 1'b0;
  endtask

  task automatic mem_start(input logic [4:0] a, input logic rd);
    Addr = a; MREQ_N = 1'b0; IORQ_N = 1'b1; RD_N = !rd; WR_N = rd;
  endtask

  task automatic io_start(input logic [3:0] aio, input logic [1:0] d);
    AddrIO = aio; D1D0 = d; IORQ_N = 1'b0; MREQ_N = 1'b1; WR_N = 1'b0; RD_N = 1'b1;
  endtask

  task automatic test_reset();
    Addr = 5'd0; AddrIO = 4'd0; D1D0 = 2'd0;
    do_reset();
    checks++;
    if ({RAM_CS_N, RAM_OE_N, RAM_WE_N} !== 3'b111) begin
      errors++; $display("FAIL reset_strobes got %b exp 111", {RAM_CS_N, RAM_OE_N, RAM_WE_N});
    end
    checks++;
    if (RAM_A1514 !== 2'b00) begin
      errors++; $display("FAIL reset_a1514 got %b exp 00", RAM_A1514);
    end
    checks++;
    if (bank !== 2'b01) begin
      errors++; $display("FAIL reset_bank got %b exp 01", bank);
    end
    checks++;
    if ({led1, led2} !== 2'b00) begin
      errors++; $display("FAIL reset_leds got %b exp 00", {led1, led2});
    end
  endtask

  task automatic test_illegal();
    Addr = 5'b11000;
    MREQ_N = 1'b0; IORQ_N = 1'b1; RD_N = 1'b1; WR_N = 1'b1;
    tick(5);
    checks++;
    if (RAM_CS_N !== 1'b1) begin
      errors++; $display("FAIL illegal_rdwr_high got %b exp 1", RAM_CS_N);
    end
    RD_N = 1'b0; WR_N = 1'b0;
    tick(5);
    checks++;
    if (RAM_CS_N !== 1'b1) begin
      errors++; $display("FAIL illegal_rdwr_low got %b exp 1", RAM_CS_N);
    end
    IORQ_N = 1'b0; RD_N = 1'b0; WR_N = 1'b1;
    tick(5);
    checks++;
    if (RAM_CS_N !== 1'b1 || bank !== 2'b01) begin
      errors++; $display("FAIL illegal_mreq_iorq got cs=%b bank=%b exp cs=1 bank=01", RAM_CS_N, bank);
    end
    bus_idle();
    tick(4);
  endtask

  task automatic test_mem_write();
    mem_start(5'b10111, 1'b0);
    tick(2);
    checks++;
    if (RAM_CS_N !== 1'b1) begin
      errors++; $display("FAIL wr_latency_early got cs=%b exp 1", RAM_CS_N);
    end
    tick(1);
    checks++;
    if ({RAM_CS_N, RAM_OE_N, RAM_WE_N, RAM_A1514} !== 5'b01000) begin
      errors++; $display("FAIL wr_active got %b exp 01000", {RAM_CS_N, RAM_OE_N, RAM_WE_N, RAM_A1514});
    end
    checks++;
    if (led1 !== 1'b1) begin
      errors++; $display("FAIL wr_led1 got %b exp 1", led1);
    end
    bus_idle();
    tick(2);
    checks++;
    if (RAM_CS_N !== 1'b0) begin
      errors++; $display("FAIL wr_hold got cs=%b exp 0", RAM_CS_N);
    end
    tick(1);
    checks++;
    if ({RAM_CS_N, RAM_OE_N, RAM_WE_N} !== 3'b111) begin
      errors++; $display("FAIL wr_release got %b exp 111", {RAM_CS_N, RAM_OE_N, RAM_WE_N});
    end
    tick(2);
  endtask

  // A one-cycle MREQ_N blip must pass through exactly one RECOVER cycle
  task automatic test_back_to_back();
    mem_start(5'b11000, 1'b1);
    tick(4);
    MREQ_N = 1'b1;
    tick(1);
    MREQ_N = 1'b0;
    tick(2);
    checks++;
    if (RAM_CS_N !== 1'b1) begin
      errors++; $display("FAIL b2b_recover_entry got cs=%b exp 1", RAM_CS_N);
    end
    tick(1);
    checks++;
    if (RAM_CS_N !== 1'b1) begin
      errors++; $display("FAIL b2b_recover_cycle got cs=%b exp 1", RAM_CS_N);
    end
    tick(1);
    checks++;
    if (RAM_CS_N !== 1'b0 || RAM_OE_N !== 1'b0) begin
      errors++; $display("FAIL b2b_restart got cs=%b oe=%b exp cs=0 oe=0", RAM_CS_N, RAM_OE_N);
    end
    bus_idle();
    tick(5);
  endtask

  task automatic test_read_window();
    do_reset();
    mem_start(5'b11000, 1'b1);
    tick(3);
    checks++;
    if ({RAM_CS_N, RAM_OE_N, RAM_WE_N, RAM_A1514} !== 5'b00101) begin
      errors++; $display("FAIL rd_c000 got %b exp 00101", {RAM_CS_N, RAM_OE_N, RAM_WE_N, RAM_A1514});
    end
    bus_idle();
    tick(5);
    mem_start(5'b10110, 1'b1);
    tick(5);
    checks++;
    if (RAM_CS_N !== 1'b1) begin
      errors++; $display("FAIL rd_outside_window got cs=%b exp 1", RAM_CS_N);
    end
    bus_idle();
    tick(4);
  endtask

  task automatic test_bank();
    logic [1:0] dv [3];
    logic [1:0] ea [3];
    dv = '{2'd2, 2'd3, 2'd0};
    ea = '{2'b10, 2'b11, 2'b01};
    for (int k = 0; k < 3; k++) begin
      io_start(4'h7, dv[k]);
      tick(3);
      checks++;
      if (bank !== dv[k] || led2 !== 1'b1) begin
        errors++; $display("FAIL bank_latch[%0d] got bank=%0d led2=%b exp bank=%0d led2=1", k, bank, led2, dv[k]);
      end
      bus_idle();
      tick(4);
      mem_start(5'b11111, 1'b1);
      tick(3);
      checks++;
      if (RAM_A1514 !== ea[k] || RAM_CS_N !== 1'b0) begin
        errors++; $display("FAIL bank_map[%0d] got a=%b cs=%b exp a=%b cs=0", k, RAM_A1514, RAM_CS_N, ea[k]);
      end
      Addr = 5'b10111;
      tick(3);
      checks++;
      if (RAM_A1514 !== ea[k]) begin
        errors++; $display("FAIL a1514_hold[%0d] got %b exp %b", k, RAM_A1514, ea[k]);
      end
      bus_idle();
      tick(5);
    end
  endtask

  task automatic test_led();
    int n;
    do_reset();
    io_start(4'h7, 2'd1);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      tick(1);
      if (i == 5) bus_idle();
      if (led2 === 1'b1) n++;
    end
    checks++;
    if (n != int'(HOLD)) begin
      errors++; $display("FAIL led2_stretch got %0d cycles exp %0d", n, HOLD);
    end
    checks++;
    if (led1 !== 1'b0 || bank !== 2'b01) begin
      errors++; $display("FAIL led_other got led1=%b bank=%b exp led1=0 bank=01", led1, bank);
    end
  endtask

  task automatic test_bad_port();
    do_reset();
    io_start(4'h6, 2'd3);
    tick(6);
    checks++;
    if (bank !== 2'b01 || led2 !== 1'b0) begin
      errors++; $display("FAIL bad_port got bank=%b led2=%b exp bank=01 led2=0", bank, led2);
    end
    bus_idle();
    tick(4);
  endtask

  task automatic test_reset_mid();
    io_start(4'h7, 2'd3);
    tick(3);
    bus_idle();
    tick(4);
    mem_start(5'b11000, 1'b1);
    tick(3);
    checks++;
    if (RAM_CS_N !== 1'b0 || RAM_A1514 !== 2'b11) begin
      errors++; $display("FAIL mid_pre got cs=%b a=%b exp cs=0 a=11", RAM_CS_N, RAM_A1514);
    end
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    checks++;
    if ({RAM_CS_N, RAM_OE_N, RAM_WE_N} !== 3'b111 || bank !== 2'b01) begin
      errors++; $display("FAIL mid_reset got strobes=%b bank=%b exp 111 01", {RAM_CS_N, RAM_OE_N, RAM_WE_N}, bank);
    end
    tick(2);
    checks++;
    if (RAM_CS_N !== 1'b1) begin
      errors++; $display("FAIL mid_resync got cs=%b exp 1", RAM_CS_N);
    end
    tick(1);
    checks++;
    if (RAM_CS_N !== 1'b0 || RAM_A1514 !== 2'b01) begin
      errors++; $display("FAIL mid_restart got cs=%b a=%b exp cs=0 a=01", RAM_CS_N, RAM_A1514);
    end
    bus_idle();
    tick(5);
  endtask

  initial begin
    rst = 1'b1;
    bus_idle();
    test_reset();
    test_illegal();
    test_mem_write();
    test_back_to_back();
    test_read_window();
    test_bank();
    test_led();
    test_bad_port();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
